// File: rtl/fht_input_loader_pkg.sv
// Shared FHT definitions: frame geometry, bit-reverse width and loader FSM encoding.
package fht_input_loader_pkg;

    localparam int FHT_N       = 1024;
    localparam int FHT_BANKS   = 4;
    localparam int FHT_REV_BIT = 10;

    localparam logic [FHT_REV_BIT-1:0] FHT_CNT_LAST = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_RDY  = 3'd5
    } fht_state_e;

    function automatic logic [FHT_BANKS-1:0] bank_onehot(input logic [1:0] bank);
        logic [FHT_BANKS-1:0] v;
        v = 4'b0001 << bank;
        return v;
    endfunction

endpackage

// File: rtl/fht_bitrev.sv
// Combinational bit reversal of a W-bit index.
module fht_bitrev #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    genvar g;
    generate
        for (g = 0; g < W; g++) begin : g_rev
            assign o_out[g] = i_in[W-1-g];
        end
    endgenerate

endmodule

// File: rtl/fht_input_loader.sv
// Loads a 1024-point natural-order frame into four bit-reversed banks,
// then starts the FHT controller and reports completion.
module fht_input_loader
    import fht_input_loader_pkg::*;
#(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iLOAD,
    input  logic             iVALID,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iFHT_RDY,
    output logic             oREADY,
    output logic [3:0]       oWE,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oDONE
);

    fht_state_e               r_state;
    fht_state_e               w_state_nxt;
    logic [FHT_REV_BIT-1:0]   r_cnt;
    logic [FHT_REV_BIT-1:0]   w_rev;
    logic                     w_accept;
    logic [FHT_BANKS-1:0]     r_we;
    logic [A_BIT-1:0]         r_addr;
    logic [D_BIT-1:0]         r_data;
    logic                     r_done;

    assign w_accept = iVALID & (r_state == ST_LOAD);

    fht_bitrev #(.W(FHT_REV_BIT)) u_bitrev (
        .i_in  (r_cnt),
        .o_out (w_rev)
    );

    // State register
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iLOAD) w_state_nxt = ST_LOAD;
                else       w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                if (w_accept && (r_cnt == FHT_CNT_LAST)) w_state_nxt = ST_FLUSH;
                else                                     w_state_nxt = ST_LOAD;
            end
            ST_FLUSH:     w_state_nxt = ST_START;
            ST_START:     w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!iFHT_RDY) w_state_nxt = ST_WAIT_RDY;
                else           w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_RDY: begin
                if (iFHT_RDY) w_state_nxt = ST_IDLE;
                else          w_state_nxt = ST_WAIT_RDY;
            end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        oREADY = 1'b0;
        oSTART = 1'b0;
        oBUSY  = 1'b1;
        case (r_state)
            ST_IDLE:  oBUSY  = 1'b0;
            ST_LOAD:  oREADY = 1'b1;
            ST_START: oSTART = 1'b1;
            default: begin
                oREADY = 1'b0;
                oSTART = 1'b0;
            end
        endcase
    end

    // Sample counter: cleared on entry to LOAD, wraps to 0 after the last sample
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_cnt <= 10'd0;
        end else if ((r_state == ST_IDLE) && iLOAD) begin
            r_cnt <= 10'd0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 10'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Bank write port, one cycle behind the accept
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_we   <= 4'b0000;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_we   <= bank_onehot(w_rev[1:0]);
            r_addr <= A_BIT'(w_rev[FHT_REV_BIT-1:2]);
            r_data <= iDATA;
        end else begin
            r_we   <= 4'b0000;
            r_addr <= r_addr;
            r_data <= r_data;
        end
    end

    // Completion pulse: set on the WAIT_RDY -> IDLE transition
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_WAIT_RDY) && iFHT_RDY;
        end
    end

    assign oWE      = r_we;
    assign oADDR_WR = r_addr;
    assign oDATA    = r_data;
    assign oDONE    = r_done;

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed testbench for fht_input_loader: bit-reversed bank loading, handshake and reset.
module tb_fht_input_loader;

    logic        iCLK;
    logic        iRESET;
    logic        iLOAD;
    logic        iVALID;
    logic [15:0] iDATA;
    logic        iFHT_RDY;
    logic        oREADY;
    logic [3:0]  oWE;
    logic [7:0]  oADDR_WR;
    logic [15:0] oDATA;
    logic        oSTART;
    logic        oBUSY;
    logic        oDONE;

    int vec;
    int err;

    int        hits    [4][256];
    logic [15:0] mem   [4][256];
    int        bank_wr [4];
    int        wr_total;
    int        we_bad;
    int        start_cnt;
    int        done_cnt;

    fht_input_loader #(.A_BIT(8), .D_BIT(16)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iLOAD    (iLOAD),
        .iVALID   (iVALID),
        .iDATA    (iDATA),
        .iFHT_RDY (iFHT_RDY),
        .oREADY   (oREADY),
        .oWE      (oWE),
        .oADDR_WR (oADDR_WR),
        .oDATA    (oDATA),
        .oSTART   (oSTART),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Bank-write and pulse logger, sampled mid-cycle
    always @(negedge iCLK) begin
        if (iRESET && (oWE != 4'b0000)) begin
            wr_total++;
            if (!(oWE == 4'b0001 || oWE == 4'b0010 || oWE == 4'b0100 || oWE == 4'b1000)) we_bad++;
            for (int b = 0; b < 4; b++) begin
                if (oWE[b]) begin
                    hits[b][oADDR_WR]++;
                    mem[b][oADDR_WR] = oDATA;
                    bank_wr[b]++;
                end
            end
        end
        if (oSTART) start_cnt++;
        if (oDONE)  done_cnt++;
    end

    function automatic logic [9:0] brev(input logic [9:0] x);
        logic [9:0] r;
        for (int b = 0; b < 10; b++) r[b] = x[9-b];
        return r;
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_mon();
        for (int b = 0; b < 4; b++) begin
            bank_wr[b] = 0;
            for (int a = 0; a < 256; a++) begin
                hits[b][a] = 0;
                mem[b][a]  = 16'h0000;
            end
        end
        wr_total  = 0;
        we_bad    = 0;
        start_cnt = 0;
        done_cnt  = 0;
    endtask

    // Counts frame cells that were not written exactly once with base+index.
    function automatic int frame_bad(input logic [15:0] base);
        int bad;
        logic [9:0] r;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            r = brev(10'(i));
            if (hits[r[1:0]][r[9:2]] != 1) bad++;
            else if (mem[r[1:0]][r[9:2]] !== base + 16'(i)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        iRESET = 1'b0; iLOAD = 1'b1; iVALID = 1'b1; iDATA = 16'h5555; iFHT_RDY = 1'b1;
        step(); step();
        vec++; if (oREADY !== 1'b0) begin err++; $display("FAIL reset_ready got=%b exp=0", oREADY); end
        vec++; if (oWE !== 4'b0000) begin err++; $display("FAIL reset_we got=%b exp=0000", oWE); end
        vec++; if ({oADDR_WR, oDATA} !== 24'h0) begin err++; $display("FAIL reset_addr_data got=%h exp=0", {oADDR_WR, oDATA}); end
        vec++; if ({oSTART, oBUSY, oDONE} !== 3'b000) begin err++; $display("FAIL reset_ctrl got=%b exp=000", {oSTART, oBUSY, oDONE}); end
        iLOAD = 1'b0; iVALID = 1'b0; iRESET = 1'b1;
        step();
        vec++; if (oBUSY !== 1'b0) begin err++; $display("FAIL post_reset_busy got=%b exp=0", oBUSY); end
    endtask

    task automatic test_load_b2b();
        int idx  [6] = '{0, 1, 2, 4, 512, 1023};
        int bank [6] = '{0, 0, 0, 0, 1, 3};
        int addr [6] = '{0, 128, 64, 32, 0, 255};
        int rdy_bad;
        clear_mon();
        rdy_bad = 0;
        // iLOAD and iVALID together in IDLE: the sample is not taken
        iLOAD = 1'b1; iVALID = 1'b1; iDATA = 16'hDEAD;
        step();
        iLOAD = 1'b0;
        vec++; if ({oREADY, oBUSY} !== 2'b11) begin err++; $display("FAIL load_entry got=%b exp=11", {oREADY, oBUSY}); end
        vec++; if (oWE !== 4'b0000) begin err++; $display("FAIL idle_sample_ignored got=%b exp=0000", oWE); end
        for (int i = 0; i < 1024; i++) begin
            if (oREADY !== 1'b1) rdy_bad++;
            iDATA = 16'(i); iVALID = 1'b1;
            step();
            for (int j = 0; j < 6; j++) begin
                if (i == idx[j]) begin
                    vec++;
                    if (oWE !== (4'b0001 << bank[j]) || oADDR_WR !== 8'(addr[j]) || oDATA !== 16'(i)) begin
                        err++;
                        $display("FAIL sample_%0d_write got we=%b addr=%0d data=%0d exp bank=%0d addr=%0d data=%0d",
                                 i, oWE, oADDR_WR, oDATA, bank[j], addr[j], i);
                    end
                end
            end
        end
        vec++; if (rdy_bad !== 0) begin err++; $display("FAIL ready_during_load got=%0d low cycles exp=0", rdy_bad); end
        vec++; if ({oREADY, oSTART} !== 2'b00) begin err++; $display("FAIL flush_cycle got ready,start=%b exp=00", {oREADY, oSTART}); end
        step();
        vec++; if ({oSTART, oREADY, oWE} !== 6'b100000) begin err++; $display("FAIL start_timing got start,ready,we=%b exp=100000", {oSTART, oREADY, oWE}); end
        iVALID = 1'b0;
        step();
        vec++; if ({oSTART, oBUSY} !== 2'b01) begin err++; $display("FAIL start_one_cycle got start,busy=%b exp=01", {oSTART, oBUSY}); end
        vec++; if (wr_total !== 1024 || we_bad !== 0) begin err++; $display("FAIL b2b_write_count got=%0d (bad we %0d) exp=1024", wr_total, we_bad); end
        vec++; if (frame_bad(16'h0000) !== 0) begin err++; $display("FAIL b2b_mapping got=%0d bad cells exp=0", frame_bad(16'h0000)); end
    endtask

    task automatic test_transform();
        repeat (3) step();
        vec++; if ({oBUSY, oDONE} !== 2'b10) begin err++; $display("FAIL wait_busy got busy,done=%b exp=10", {oBUSY, oDONE}); end
        iFHT_RDY = 1'b0;
        for (int k = 0; k < 5200; k++) begin
            iLOAD = (k == 2600);
            step();
        end
        iLOAD = 1'b0;
        vec++; if ({oBUSY, oREADY, oDONE} !== 3'b100) begin err++; $display("FAIL load_in_wait_rdy got busy,ready,done=%b exp=100", {oBUSY, oREADY, oDONE}); end
        iFHT_RDY = 1'b1;
        step();
        vec++; if ({oDONE, oBUSY} !== 2'b10) begin err++; $display("FAIL done_pulse got done,busy=%b exp=10", {oDONE, oBUSY}); end
        step();
        vec++; if ({oDONE, oBUSY} !== 2'b00) begin err++; $display("FAIL done_single got done,busy=%b exp=00", {oDONE, oBUSY}); end
        vec++; if (done_cnt !== 1 || start_cnt !== 1) begin err++; $display("FAIL pulse_counts got done=%0d start=%0d exp=1,1", done_cnt, start_cnt); end
    endtask

    task automatic test_valid_gaps();
        int gap_bad;
        clear_mon();
        gap_bad = 0;
        iLOAD = 1'b1;
        step();
        iLOAD = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            iVALID = (k % 2 == 0);
            iLOAD  = (k == 601);
            iDATA  = 16'h4000 + 16'(k / 2);
            step();
            if ((k % 2 == 1) && (oWE !== 4'b0000)) gap_bad++;
        end
        iVALID = 1'b0; iLOAD = 1'b0;
        vec++; if (oSTART !== 1'b1) begin err++; $display("FAIL gaps_start_timing got=%b exp=1", oSTART); end
        vec++; if (gap_bad !== 0) begin err++; $display("FAIL gaps_idle_we got=%0d exp=0", gap_bad); end
        vec++; if (wr_total !== 1024) begin err++; $display("FAIL gaps_write_count got=%0d exp=1024", wr_total); end
        vec++; if (bank_wr[0] !== 256 || bank_wr[1] !== 256 || bank_wr[2] !== 256 || bank_wr[3] !== 256) begin
            err++; $display("FAIL gaps_bank_counts got=%0d,%0d,%0d,%0d exp=256 each", bank_wr[0], bank_wr[1], bank_wr[2], bank_wr[3]);
        end
        vec++; if (frame_bad(16'h4000) !== 0) begin err++; $display("FAIL gaps_mapping got=%0d bad cells exp=0", frame_bad(16'h4000)); end
    endtask

    task automatic test_reset_mid_transform();
        int d0;
        step();
        iFHT_RDY = 1'b0;
        repeat (10) step();
        iRESET = 1'b0;
        #2;
        vec++; if (oBUSY !== 1'b0) begin err++; $display("FAIL reset_mid_fht_busy got=%b exp=0", oBUSY); end
        step();
        iRESET = 1'b1; iFHT_RDY = 1'b1;
        d0 = done_cnt;
        repeat (20) step();
        vec++; if (done_cnt !== d0 || oBUSY !== 1'b0) begin err++; $display("FAIL reset_mid_fht_abandon got done=%0d busy=%b exp=%0d,0", done_cnt, oBUSY, d0); end
    endtask

    task automatic test_reset_mid_load();
        int s0;
        int we_seen;
        iLOAD = 1'b1;
        step();
        iLOAD = 1'b0;
        for (int i = 0; i < 500; i++) begin
            iVALID = 1'b1; iDATA = 16'h0100 + 16'(i);
            step();
        end
        iVALID = 1'b0;
        iRESET = 1'b0;
        #2;
        vec++; if ({oREADY, oWE, oADDR_WR, oDATA, oSTART, oBUSY, oDONE} !== 31'h0) begin
            err++; $display("FAIL reset_mid_load_outputs got=%h exp=0", {oREADY, oWE, oADDR_WR, oDATA, oSTART, oBUSY, oDONE});
        end
        step();
        iRESET = 1'b1;
        s0 = start_cnt;
        we_seen = 0;
        for (int k = 0; k < 10; k++) begin
            iVALID = 1'b1;
            step();
            if (oWE !== 4'b0000) we_seen++;
        end
        iVALID = 1'b0;
        vec++; if (start_cnt !== s0 || we_seen !== 0 || oBUSY !== 1'b0) begin
            err++; $display("FAIL reset_mid_load_abandon got start=%0d writes=%0d busy=%b exp=%0d,0,0", start_cnt, we_seen, oBUSY, s0);
        end
        iLOAD = 1'b1;
        step();
        iLOAD = 1'b0; iVALID = 1'b1; iDATA = 16'hABCD;
        step();
        vec++; if (oWE !== 4'b0001 || oADDR_WR !== 8'd0 || oDATA !== 16'hABCD) begin
            err++; $display("FAIL restart_first got we=%b addr=%0d data=%h exp=0001,0,abcd", oWE, oADDR_WR, oDATA);
        end
        iDATA = 16'h1234;
        step();
        iVALID = 1'b0;
        vec++; if (oWE !== 4'b0001 || oADDR_WR !== 8'd128 || oDATA !== 16'h1234) begin
            err++; $display("FAIL restart_second got we=%b addr=%0d data=%h exp=0001,128,1234", oWE, oADDR_WR, oDATA);
        end
    endtask

    initial begin
        vec = 0;
        err = 0;
        clear_mon();
        iRESET = 1'b0; iLOAD = 1'b0; iVALID = 1'b0; iDATA = 16'h0000; iFHT_RDY = 1'b1;
        test_reset();
        test_load_b2b();
        test_transform();
        test_valid_gaps();
        test_reset_mid_transform();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
